// File: rtl/app_arbit_rr_if.sv
// Handshake bundle between the per-channel DMA masters and the round-robin arbiter.
interface app_arbit_rr_if #(
    parameter int CH_NUM = 4,
    parameter int IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
);
    logic [CH_NUM-1:0] I_req;
    logic [CH_NUM-1:0] I_start;
    logic [CH_NUM-1:0] I_end;
    logic [CH_NUM-1:0] O_vaild;
    logic [IDX_W-1:0]  O_grant_idx;
    logic              O_busy;
    logic              O_timeout;

    // Channel side: raises requests and start/end strobes, watches the grant.
    modport master (
        output I_req, I_start, I_end,
        input  O_vaild, O_grant_idx, O_busy, O_timeout
    );

    // Arbiter side.
    modport slave (
        input  I_req, I_start, I_end,
        output O_vaild, O_grant_idx, O_busy, O_timeout
    );
endinterface

// File: rtl/app_arbit_rr.sv
// N-channel round-robin arbiter for the DDR3 native-port DMA layer.
// One channel at a time is offered the command path; it must raise start
// within TO_CYC cycles (or lose the offer) and then pulse end to release it.
module app_arbit_rr #(
    parameter int CH_NUM = 4,
    parameter int IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int TO_W   = 16,
    parameter int TO_CYC = 1024
) (
    input  logic          I_clk,
    input  logic          I_Rst_n,
    app_arbit_rr_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2,
        ST_XFER  = 2'd3
    } state_t;

    // Reset pointer sits on the last channel so channel 0 wins the first round.
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(CH_NUM - 1);
    localparam bit               TO_EN   = (TO_CYC != 0);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TO_CYC == 0) ? 0 : TO_CYC - 1);

    state_t            state_q,    state_nxt;
    logic [CH_NUM-1:0] vaild_q,    vaild_nxt;
    logic [IDX_W-1:0]  idx_q,      idx_nxt;
    logic              timeout_q,  timeout_nxt;
    logic [IDX_W-1:0]  last_ptr_q, last_ptr_nxt;
    logic [CH_NUM-1:0] snap_q,     snap_nxt;
    logic [TO_W-1:0]   to_cnt_q,   to_cnt_nxt;
    logic [CH_NUM-1:0] start_d_q;

    logic [CH_NUM-1:0] start_rise;
    logic              owner_start;
    logic              owner_end;
    logic [IDX_W-1:0]  win_idx;

    // First requesting channel after the last winner, wrapping modulo CH_NUM.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [CH_NUM-1:0] snap,
        input logic [IDX_W-1:0]  last
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               cand;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= CH_NUM; i++) begin
            cand = (int'(last) + i) % CH_NUM;
            if (!found && snap[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
        return pick;
    endfunction

    // Only the owner's strobes matter; idx_q holds the owner from ARB onward.
    assign start_rise  = bus.I_start & ~start_d_q;
    assign owner_start = start_rise[idx_q];
    assign owner_end   = bus.I_end[idx_q];
    assign win_idx     = rr_pick(snap_q, last_ptr_q);

    // Next-state and next-output decode for the arbitration FSM.
    always_comb begin
        // NOTE: every target gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt    = state_q;
        vaild_nxt    = vaild_q;
        idx_nxt      = idx_q;
        timeout_nxt  = 1'b0;
        last_ptr_nxt = last_ptr_q;
        snap_nxt     = snap_q;
        to_cnt_nxt   = to_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.I_req) begin
                    snap_nxt  = bus.I_req;
                    state_nxt = ST_ARB;
                end
            end

            ST_ARB: begin
                vaild_nxt    = CH_NUM'(1) << win_idx;
                idx_nxt      = win_idx;
                last_ptr_nxt = win_idx;
                to_cnt_nxt   = '0;
                state_nxt    = ST_GRANT;
            end

            ST_GRANT: begin
                // A start edge on the timeout cycle still counts as a start.
                if (owner_start) begin
                    vaild_nxt = '0;
                    state_nxt = ST_XFER;
                end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
                    vaild_nxt   = '0;
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end else if (TO_EN) begin
                    to_cnt_nxt = to_cnt_q + TO_W'(1);
                end
            end

            ST_XFER: begin
                if (owner_end) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge I_clk or negedge I_Rst_n) begin
        // NOTE: these are plain flops, not a memory, so every one of them is put in reset.
        if (!I_Rst_n) begin
            state_q    <= ST_IDLE;
            vaild_q    <= '0;
            idx_q      <= '0;
            timeout_q  <= 1'b0;
            last_ptr_q <= PTR_RST;
            snap_q     <= '0;
            to_cnt_q   <= '0;
            start_d_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_nxt;
            vaild_q    <= vaild_nxt;
            idx_q      <= idx_nxt;
            timeout_q  <= timeout_nxt;
            last_ptr_q <= last_ptr_nxt;
            snap_q     <= snap_nxt;
            to_cnt_q   <= to_cnt_nxt;
            start_d_q  <= bus.I_start;
        end
    end

    assign bus.O_vaild     = vaild_q;
    assign bus.O_grant_idx = idx_q;
    assign bus.O_busy      = (state_q != ST_IDLE);
    assign bus.O_timeout   = timeout_q;

endmodule

// File: tb/tb_app_arbit_rr.sv
// Self-checking bench for app_arbit_rr: a transaction-level model tracks who
// owns the offer and is compared every cycle; directed scenarios pin grant
// orders, latency and timeout length to hand-computed literals.
module tb_app_arbit_rr;

    localparam int N      = 4;
    localparam int TO_CYC = 8;

    logic I_clk   = 1'b0;
    logic I_Rst_n = 1'b0;

    app_arbit_rr_if #(.CH_NUM(N)) bus ();

    app_arbit_rr #(
        .CH_NUM(N),
        .TO_W  (16),
        .TO_CYC(TO_CYC)
    ) dut (
        .I_clk  (I_clk),
        .I_Rst_n(I_Rst_n),
        .bus    (bus)
    );

    always #5 I_clk = ~I_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int to_seen  = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Ownership view: who holds the offer, whether a transfer is running,
    // and how long the offer has been waiting for its start strobe.
    typedef struct {
        bit         pending;     // request snapshot taken, winner chosen next
        bit         offered;     // owner is being offered the path
        bit         xfer;        // owner is transferring
        int         owner;
        int         shown_idx;
        int         last;
        int         waited;
        logic [3:0] snap;
        logic [3:0] prev_start;
        bit         tout;
    } model_t;

    model_t m;

    function automatic model_t m_reset();
        model_t r;
        r.pending = 0; r.offered = 0; r.xfer = 0;
        r.owner = -1; r.shown_idx = 0; r.last = N - 1; r.waited = 0;
        r.snap = '0; r.prev_start = '0; r.tout = 0;
        return r;
    endfunction

    // Closest requester going forward from the last winner.
    function automatic int m_pick(input logic [3:0] snap, input int last);
        int best, bestd, d;
        best = -1; bestd = N;
        for (int c = 0; c < N; c++) begin
            if (snap[c]) begin
                d = (c - last - 1 + 2 * N) % N;
                if (d < bestd) begin best = c; bestd = d; end
            end
        end
        return best;
    endfunction

    function automatic model_t m_step(input model_t s, input logic [3:0] req,
                                      input logic [3:0] st, input logic [3:0] en);
        model_t r;
        logic [3:0] rise;
        r = s;
        r.tout = 0;
        rise = st & ~s.prev_start;
        if (s.pending) begin
            r.owner = m_pick(s.snap, s.last);
            r.last = r.owner; r.shown_idx = r.owner;
            r.pending = 0; r.offered = 1; r.waited = 0;
        end else if (s.offered) begin
            if (rise[s.owner]) begin
                r.offered = 0; r.xfer = 1;
            end else if (TO_CYC != 0 && s.waited == TO_CYC - 1) begin
                r.offered = 0; r.tout = 1; r.owner = -1;
            end else if (TO_CYC != 0) begin
                r.waited = s.waited + 1;
            end
        end else if (s.xfer) begin
            if (en[s.owner]) begin r.xfer = 0; r.owner = -1; end
        end else if (req != 0) begin
            r.snap = req; r.pending = 1;
        end
        r.prev_start = st;
        return r;
    endfunction

    initial m = m_reset();

    always @(posedge I_clk or negedge I_Rst_n) begin
        if (!I_Rst_n) m <= m_reset();
        else          m <= m_step(m, bus.I_req, bus.I_start, bus.I_end);
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge I_clk) begin
        if (I_Rst_n && chk_en) begin
            check("vaild",     int'(bus.O_vaild),     m.offered ? (1 << m.owner) : 0);
            check("grant_idx", int'(bus.O_grant_idx), m.shown_idx);
            check("busy",      int'(bus.O_busy),      int'(m.pending | m.offered | m.xfer));
            check("timeout",   int'(bus.O_timeout),   int'(m.tout));
        end
        if (I_Rst_n && bus.O_timeout) to_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge I_clk);
        #1;
    endtask

    task automatic zero_inputs();
        bus.I_req = '0; bus.I_start = '0; bus.I_end = '0;
    endtask

    task automatic do_reset();
        I_Rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.I_req = 4'($urandom); bus.I_start = 4'($urandom); bus.I_end = 4'($urandom);
            cyc();
            check("rst_vaild", int'(bus.O_vaild), 0);
            check("rst_busy",  int'(bus.O_busy), 0);
            check("rst_idx",   int'(bus.O_grant_idx), 0);
        end
        zero_inputs();
        I_Rst_n = 1'b1;
        cyc();
    endtask

    task automatic wait_offer(input int budget, output int idx);
        idx = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.O_vaild != 0) begin
                for (int c = 0; c < N; c++) if (bus.O_vaild[c]) idx = c;
                break;
            end
            cyc();
        end
        if (idx < 0) begin
            check("offer_wait", 0, 1);
            idx = 0;
        end
    endtask

    // Owner raises start for one cycle, then pulses end.
    task automatic serve(input int ch);
        bus.I_start[ch] = 1'b1;
        cyc();
        bus.I_start[ch] = 1'b0;
        bus.I_end[ch]   = 1'b1;
        cyc();
        bus.I_end[ch]   = 1'b0;
    endtask

    task automatic run_order(input logic [3:0] req, input int cnt, output int order[8]);
        int idx;
        bus.I_req = req;
        for (int k = 0; k < cnt; k++) begin
            wait_offer(20, idx);
            order[k] = idx;
            if (k == cnt - 1) bus.I_req = '0;
            serve(idx);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int idx, cnt, to_before;
        int order[8];
        int exp_rot[5]  = '{0, 1, 2, 3, 0};
        int exp_fair[4] = '{3, 1, 3, 1};

        zero_inputs();
        chk_en = 1'b1;

        // Reset state and two-cycle request-to-offer latency.
        do_reset();
        bus.I_req = 4'b0100;
        cyc();
        check("lat_arb_busy",  int'(bus.O_busy), 1);
        check("lat_arb_vaild", int'(bus.O_vaild), 0);
        cyc();
        check("lat_vaild", int'(bus.O_vaild), 4);
        check("lat_idx",   int'(bus.O_grant_idx), 2);
        bus.I_req = '0;
        serve(2);
        cyc();
        check("lat_done_busy", int'(bus.O_busy), 0);

        // Rotation with all channels requesting.
        do_reset();
        to_before = to_seen;
        run_order(4'b1111, 5, order);
        for (int k = 0; k < 5; k++) check($sformatf("rot_%0d", k), order[k], exp_rot[k]);
        check("rot_no_timeout", to_seen - to_before, 0);

        // Fairness skip: move pointer to 1, then two requesters.
        run_order(4'b0010, 1, order);
        check("fair_setup", order[0], 1);
        run_order(4'b1010, 4, order);
        for (int k = 0; k < 4; k++) check($sformatf("fair_%0d", k), order[k], exp_fair[k]);

        // Start timeout on channel 0.
        bus.I_req = 4'b0001;
        wait_offer(20, idx);
        check("to_idx", idx, 0);
        bus.I_req = '0;
        cnt = 0;
        while (bus.O_vaild[0] && cnt < 20) begin
            cnt++;
            cyc();
        end
        check("to_len", cnt, 8);
        check("to_pulse", int'(bus.O_timeout), 1);
        cyc();
        check("to_pulse_end", int'(bus.O_timeout), 0);
        bus.I_req = 4'b0011;
        wait_offer(20, idx);
        check("to_next_idx", idx, 1);
        bus.I_req = '0;
        serve(idx);

        // Start already high on entry, then wrong-channel end.
        bus.I_req = 4'b0100;
        bus.I_start[2] = 1'b1;
        wait_offer(20, idx);
        check("hs_idx", idx, 2);
        bus.I_req = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("hs_hold", int'(bus.O_vaild), 4);
        end
        bus.I_start[2] = 1'b0;
        cyc();
        check("hs_low", int'(bus.O_vaild), 4);
        bus.I_start[2] = 1'b1;
        cyc();
        check("hs_xfer_vaild", int'(bus.O_vaild), 0);
        check("hs_xfer_busy",  int'(bus.O_busy), 1);
        bus.I_start[2] = 1'b0;
        bus.I_end[0]   = 1'b1;
        cyc();
        check("hs_wrong_end", int'(bus.O_busy), 1);
        bus.I_end[0] = 1'b0;
        bus.I_end[2] = 1'b1;
        cyc();
        check("hs_end", int'(bus.O_busy), 0);
        bus.I_end[2] = 1'b0;

        // Randomised traffic, model-checked every cycle.
        for (int i = 0; i < 1500; i++) begin
            bus.I_req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            for (int c = 0; c < N; c++) begin
                bus.I_start[c] = ($urandom_range(0, 3) == 0);
                bus.I_end[c]   = ($urandom_range(0, 4) == 0);
            end
            cyc();
        end

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        bus.I_req = 4'b1111;
        wait_offer(20, idx);
        bus.I_req = '0;
        bus.I_start[idx] = 1'b1;
        cyc();
        check("mid_xfer_busy", int'(bus.O_busy), 1);
        #2;
        I_Rst_n = 1'b0;
        #1;
        check("async_busy",  int'(bus.O_busy), 0);
        check("async_vaild", int'(bus.O_vaild), 0);
        check("async_idx",   int'(bus.O_grant_idx), 0);
        zero_inputs();
        cyc();
        I_Rst_n = 1'b1;
        cyc();
        bus.I_req = 4'b1000;
        wait_offer(20, idx);
        check("post_rst_idx", idx, 3);
        bus.I_req = '0;
        serve(idx);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global bound so a stuck handshake cannot hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/app_arbit_rr.md
Name: app_arbit_rr

Overview:
- Parametrised N-channel round-robin arbiter for the DDR3 native-port DMA application layer.
- Grants exclusive access to one channel at a time using a req/valid/start/end handshake.
- Sits between the per-channel read/write DMA masters and the shared DDR3 command path.
- Adds channel-count scaling, rotating priority, a grant-index output and a start-timeout abort.

Parameters:
- CH_NUM, 4, number of requesting channels (2..16).
- IDX_W, $clog2(CH_NUM) (minimum 1), width of the grant index.
- TO_W, 16, width of the timeout counter.
- TO_CYC, 1024, cycles in GRANT to wait for start; 0 disables the timeout.

Ports:
- I_clk  in  1  system clock.
- I_Rst_n  in  1  asynchronous active-low reset.
- I_req  in  CH_NUM  per-channel access request, level.
- I_start  in  CH_NUM  per-channel transfer-start; only the rising edge is used.
- I_end  in  CH_NUM  per-channel transfer-done, single-cycle pulse.
- O_vaild  out  CH_NUM  one-hot grant-offer to the selected channel.
- O_grant_idx  out  IDX_W  index of the current or last granted channel.
- O_busy  out  1  high whenever state != IDLE.
- O_timeout  out  1  one-cycle pulse when a grant is withdrawn for lack of start.

Behaviour:
- Single clock domain. All state is reset asynchronously by I_Rst_n low.
- Reset values: state=IDLE, O_vaild=0, O_grant_idx=0, O_busy=0, O_timeout=0, last_ptr=CH_NUM-1 (channel 0 wins first), req_snap=0, start_d=0, to_cnt=0.
- start_d registers I_start every cycle. Rising edge of channel k = I_start[k] & ~start_d[k].
- State IDLE:
  - If |I_req: req_snap <= I_req, go to ARB.
  - Otherwise stay in IDLE.
- State ARB (exactly one cycle):
  - Winner w = first set bit of req_snap, searching last_ptr+1, last_ptr+2, ... modulo CH_NUM.
  - On the same edge: O_vaild <= one-hot(w), O_grant_idx <= w, last_ptr <= w, to_cnt <= 0, go to GRANT.
  - req_snap is non-zero by construction.
- State GRANT:
  - O_vaild holds one-hot(w).
  - On the rising edge of I_start[w]: O_vaild <= 0, go to XFER.
  - Otherwise, if TO_CYC != 0, to_cnt increments. When to_cnt == TO_CYC-1 and no start edge occurs: O_vaild <= 0, O_timeout <= 1 for one cycle, go to IDLE. last_ptr stays = w, so w has lowest priority next round.
  - If the start edge and the timeout coincide, start wins (go to XFER, no timeout pulse).
- State XFER:
  - Wait for I_end[w]==1, then go to IDLE.
  - I_start and I_end from other channels are ignored in every state.
  - I_end[w] outside XFER is ignored.
- Latency: I_req sampled high in IDLE at edge t → ARB at t+1 → O_vaild high after edge t+2. End at edge e → IDLE at e+1 → next O_vaild at earliest e+3.
- Deasserting I_req after the snapshot does not cancel the grant. The channel must still start/end or let the grant time out.
- A channel holding I_req continuously is re-granted only after every other requesting channel has been served once (strict rotation).
- Reset asserted mid-GRANT or mid-XFER: all outputs go to reset values immediately (asynchronous). The arbitration pointer returns to CH_NUM-1.
- O_grant_idx holds its value through IDLE until the next ARB.

Test Plan:
- Reset: hold I_Rst_n=0 with random inputs → O_vaild=0, O_busy=0, O_grant_idx=0. Release, then I_req=4'b0100 → O_vaild=4'b0100, O_grant_idx=2, exactly 2 cycles after the request is sampled.
- Rotation: I_req=4'b1111 held; each grant completed with a start pulse then an end pulse → grant order 0,1,2,3,0. O_timeout never pulses.
- Fairness skip: I_req=4'b1010 held, last_ptr=1 → order 3,1,3,1.
- Timeout: TO_CYC=8, I_req=4'b0001, I_start never rises → O_vaild[0] high for 8 cycles then drops, O_timeout=1 for one cycle. Then with I_req=4'b0011, channel 1 is granted before channel 0.
- Handshake robustness: I_start[w] already high on GRANT entry → no edge, stays in GRANT. Next 0→1 moves to XFER. Wrong-channel I_end pulse in XFER → stays in XFER. I_end[w] → IDLE.
- Reset mid-XFER: assert I_Rst_n=0 asynchronously between clock edges → O_busy=0 and O_vaild=0 before the next edge. After release, I_req=4'b1000 → grant index 3.
